// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: ALU and multiply/divide operation codes plus helpers.
package mips_cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  // Magnitude of x when treated as signed; pass-through for unsigned ops.
  function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_fixup.sv
// Sign correction: unsigned magnitude results plus sign flags -> signed HI/LO.
module mips_cpu_muldiv_fixup
  import mips_cpu_pkg::*;
(
  input  logic              is_div_i,
  input  logic              neg_res_i,
  input  logic              neg_rem_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [XLEN-1:0]   hi_c_o,
  output logic [XLEN-1:0]   lo_c_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // Product negates as a whole; quotient and remainder carry independent signs.
  always_comb begin
    prod_s = neg_res_i ? -prod_i : prod_i;
    quo_s  = neg_res_i ? -prod_i[XLEN-1:0] : prod_i[XLEN-1:0];
    rem_s  = neg_rem_i ? -rem_i : rem_i;
    hi_c_o = is_div_i ? rem_s : prod_s[2*XLEN-1:XLEN];
    lo_c_o = is_div_i ? quo_s : prod_s[XLEN-1:0];
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;   // product, or {0, dividend->quotient}
  logic [XLEN:0]       rem_q, rem_d;     // 33-bit partial remainder
  logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;

  md_op_e            op_e;
  logic              sgn;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_sh, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign op_e     = md_op_e'(op);
  assign sgn      = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign mag_a    = mag_of(a, sgn);
  assign mag_b    = mag_of(b, sgn);
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {rem_q, prod_q[XLEN-1]};
  assign div_diff = div_sh - {2'b00, opnd_q};
  assign div_ok   = ~div_diff[XLEN+1];

  mips_cpu_muldiv_fixup u_fixup (
    .is_div_i  (is_div_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .prod_i    (prod_q),
    .rem_i     (rem_q[XLEN-1:0]),
    .hi_c_o    (fix_hi),
    .lo_c_o    (fix_lo)
  );

  // State and datapath registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: operand capture in IDLE, one bit per cycle in CALC, write-back in FIXUP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op_e)
            MD_MULT, MD_MULTU: begin
              opnd_d    = mag_a;
              prod_d    = {{XLEN{1'b0}}, mag_b};
              rem_d     = '0;
              is_div_d  = 1'b0;
              neg_res_d = sgn & (a[XLEN-1] ^ b[XLEN-1]);
              neg_rem_d = 1'b0;
              cnt_d     = '0;
              state_d   = S_CALC;
            end
            MD_DIV, MD_DIVU: begin
              is_div_d = 1'b1;
              cnt_d    = '0;
              if (b == '0) begin
                // Divide by zero: preload the fixed result, no sign correction.
                prod_d    = {{XLEN{1'b0}}, {XLEN{1'b1}}};
                rem_d     = {1'b0, a};
                neg_res_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = S_FIXUP;
              end else begin
                opnd_d    = mag_b;
                prod_d    = {{XLEN{1'b0}}, mag_a};
                rem_d     = '0;
                neg_res_d = sgn & (a[XLEN-1] ^ b[XLEN-1]);
                neg_rem_d = sgn & a[XLEN-1];
                state_d   = S_CALC;
              end
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_NOP6, MD_NOP7: ;
          endcase
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          rem_d  = div_ok ? div_diff[XLEN:0] : div_sh[XLEN:0];
          prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], div_ok};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + MD_CNT_W'(1);
        if (cnt_q == MD_CNT_W'(MD_ITERS - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
